dual_lane_dispatch: RTL and testbench
=====================================

DUAL_LANE_DISPATCH -- requirements
Module: dual_lane_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning input buffer entries (power of two, >=2).
REQ-002 SHALL have parameter LANE2_OPCODE, default 5'd6, meaning the opcode routed to lane 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  decoded instruction offered.
REQ-006 SHALL have port in_instr  input  58  {opcode[4:0], rd[6:0], rs1[6:0], rs2[6:0], imm[31:0]}.
REQ-007 SHALL have port in_ready  output  1  buffer can accept.
REQ-008 SHALL have port l1_valid  output  1  instruction presented to lane 1.
REQ-009 SHALL have port l1_instr  output  58  lane 1 instruction.
REQ-010 SHALL have port l1_ready  input  1  lane 1 accepts.
REQ-011 SHALL have port l2_valid  output  1  instruction presented to lane 2.
REQ-012 SHALL have port l2_instr  output  58  lane 2 instruction.
REQ-013 SHALL have port l2_ready  input  1  lane 2 accepts.
REQ-014 SHALL have port wb_en  input  1  merged write-back valid.
REQ-015 SHALL have port wb_rd  input  7  merged write-back destination register.
REQ-016 SHALL have port stall_cnt  output  16  saturating count of hazard-stall cycles.

Function
REQ-017 SHALL push in_instr into an in-order FIFO when in_valid && in_ready; in_ready = !full.
REQ-018 SHALL NOT accept a push while full, even if the head issues in that cycle.
REQ-019 SHALL route the head to lane 2 when opcode == LANE2_OPCODE, otherwise to lane 1; never both.
REQ-020 SHALL assert the selected lane valid only when head present and busy[rs1], busy[rs2], busy[rd] are all clear; register 0 is never busy.
REQ-021 SHALL drive lN_instr from the FIFO head; the unselected lane's instr SHALL be 0 and its valid 0.
REQ-022 SHALL issue (pop) when lN_valid && lN_ready; at most one issue per cycle, strictly in order.
REQ-023 SHALL make an instruction pushed at edge N visible at the head no earlier than the cycle after edge N (minimum push-to-issue latency 1 cycle).
REQ-024 SHALL hold l*_valid and l*_instr stable until accepted once asserted (no retraction).
REQ-025 SHALL keep a 128-bit busy scoreboard: on issue with rd != 0 set busy[rd]; on wb_en clear busy[wb_rd].
REQ-026 SHALL give set priority when issue-set and wb-clear target the same register in the same cycle.
REQ-027 SHALL increment stall_cnt each cycle the head is present but blocked by a hazard (not by lane ready), saturating at 16'hFFFF.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-029 SHALL, on rst_n low (any time, mid-operation included), empty the FIFO, clear all busy bits, zero stall_cnt, drive in_ready=0, l1_valid=l2_valid=0, instr outputs 0.
REQ-030 SHALL raise in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with DISPATCH_BYPASS_EN defined, let wb_en/wb_rd clear the hazard for the issue check in the same cycle.
REQ-032 SHALL, without DISPATCH_BYPASS_EN, make a wb clear visible to the issue check one cycle later.

Structure
REQ-033 SHALL place instr_t packed struct, REG_W=7, OPC_W=5, NUM_REGS=128 in package dispatch_pkg.
REQ-034 SHALL implement the buffer as sub-module dispatch_fifo (parameterised by FIFO_DEPTH and instr_t).

Verification
REQ-035 SHALL cover: push opcode 3 rd=5 with l1_ready=1 -> l1_valid next cycle, issued, busy[5]=1, l2_valid never high.
REQ-036 SHALL cover: opcode 6 rs1=5 while busy[5] -> l2_valid=0, stall_cnt increments; wb_en wb_rd=5 -> issue same cycle (bypass) or one cycle later (no bypass).
REQ-037 SHALL cover: 4 pushes with l1_ready=0 -> in_ready=0 after 4th; 5th offer is not accepted; l1_ready=1 -> drains in order.
REQ-038 SHALL cover: issue rd=9 and wb_rd=9 in the same cycle -> busy[9]=1 afterward.
REQ-039 SHALL cover: rst_n low with 3 entries buffered and busy[7] set -> empty, busy clear, stall_cnt=0 asynchronously.
REQ-040 SHALL cover: 70000 forced hazard cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and widths for the dual-lane dispatch block.
package dispatch_pkg;

    localparam int unsigned REG_W    = 7;
    localparam int unsigned OPC_W    = 5;
    localparam int unsigned NUM_REGS = 128;
    localparam int unsigned IMM_W    = 32;
    localparam int unsigned INSTR_W  = OPC_W + 3 * REG_W + IMM_W;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } instr_t;

endpackage

// File: rtl/dispatch_fifo.sv
// In-order instruction buffer; pointers carry an extra wrap bit to tell full from empty.
module dispatch_fifo
    import dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type         T          = instr_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     head,
    output logic empty,
    output logic full
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    T           mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dual_lane_dispatch.sv
// In-order two-lane issue with a register busy scoreboard and hazard-stall counter.
// Optional macro DISPATCH_BYPASS_EN: write-back clears the hazard in the same cycle.
module dual_lane_dispatch
    import dispatch_pkg::*;
#(
    parameter int unsigned      FIFO_DEPTH   = 4,
    parameter logic [OPC_W-1:0] LANE2_OPCODE = 5'd6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic               l1_valid,
    output logic [INSTR_W-1:0] l1_instr,
    input  logic               l1_ready,
    output logic               l2_valid,
    output logic [INSTR_W-1:0] l2_instr,
    input  logic               l2_ready,
    input  logic               wb_en,
    input  logic [REG_W-1:0]   wb_rd,
    output logic [15:0]        stall_cnt
);

    instr_t              head;
    logic                empty;
    logic                full;
    logic                issue;
    logic                hazard;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_chk;

    // full is registered state, so a same-cycle pop never opens a slot for a push
    assign in_ready = rst_n && !full;

    dispatch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T          (instr_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata (instr_t'(in_instr)),
        .pop   (issue),
        .head  (head),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        busy_chk = busy;
`ifdef DISPATCH_BYPASS_EN
        if (wb_en)
            busy_chk[wb_rd] = 1'b0;
`endif
        hazard   = busy_chk[head.rs1] | busy_chk[head.rs2] | busy_chk[head.rd];
        l1_valid = 1'b0;
        l2_valid = 1'b0;
        l1_instr = '0;
        l2_instr = '0;
        if (!empty) begin
            if (head.opcode == LANE2_OPCODE) begin
                l2_instr = head;
                l2_valid = !hazard;
            end else begin
                l1_instr = head;
                l1_valid = !hazard;
            end
        end
        issue = (l1_valid && l1_ready) || (l2_valid && l2_ready);
    end

    // set is applied after clear so an issue wins over a same-register write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wb_en)
                busy[wb_rd] <= 1'b0;
            if (issue && (head.rd != '0))
                busy[head.rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!empty && hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_dual_lane_dispatch.sv
// Directed self-checking bench for dual_lane_dispatch (follows DISPATCH_BYPASS_EN if defined).
module tb_dual_lane_dispatch;
    import dispatch_pkg::*;

`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               l1_valid;
    logic [INSTR_W-1:0] l1_instr;
    logic               l1_ready;
    logic               l2_valid;
    logic [INSTR_W-1:0] l2_instr;
    logic               l2_ready;
    logic               wb_en;
    logic [REG_W-1:0]   wb_rd;
    logic [15:0]        stall_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    dual_lane_dispatch #(
        .FIFO_DEPTH   (4),
        .LANE2_OPCODE (5'd6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .l1_valid  (l1_valid),
        .l1_instr  (l1_instr),
        .l1_ready  (l1_ready),
        .l2_valid  (l2_valid),
        .l2_instr  (l2_instr),
        .l2_ready  (l2_ready),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [4:0] op, input logic [6:0] rd,
                                              input logic [6:0] rs1, input logic [6:0] rs2,
                                              input logic [31:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb_pulse(input logic [6:0] r);
        wb_en = 1'b1;
        wb_rd = r;
        step();
        wb_en = 1'b0;
    endtask

    logic [INSTR_W-1:0] ia, ib, ic, id, ie, ih;
    logic [INSTR_W-1:0] cq [5];
    logic [15:0] s2, s4;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
        l1_ready = 1'b0; l2_ready = 1'b0; wb_en = 1'b0; wb_rd = '0;
        #2;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_l1_valid", l1_valid, 0);
        check_eq("rst_l2_valid", l2_valid, 0);
        check_eq("rst_l1_instr", l1_instr, 0);
        check_eq("rst_stall", stall_cnt, 0);
        step(); step();
        rst_n = 1'b1;
        settle();
        check_eq("post_rst_in_ready", in_ready, 1);

        // lane 1 issue, sets busy[5]
        l1_ready = 1'b1; l2_ready = 1'b1;
        ia = mk(5'd3, 7'd5, 7'd1, 7'd2, 32'hA5A5_0001);
        in_valid = 1'b1; in_instr = ia;
        settle();
        check_eq("lat_l1_valid_before", l1_valid, 0);
        step();
        in_valid = 1'b0;
        settle();
        check_eq("t1_l1_valid", l1_valid, 1);
        check_eq("t1_l1_instr", l1_instr, ia);
        check_eq("t1_l2_valid", l2_valid, 0);
        check_eq("t1_l2_instr", l2_instr, 0);
        step();
        settle();
        check_eq("t1_drained", l1_valid, 0);
        check_eq("t1_l2_never", l2_valid, 0);

        // lane 2 routing without hazard
        ic = mk(5'd6, 7'd12, 7'd0, 7'd0, 32'h0000_0C0C);
        in_valid = 1'b1; in_instr = ic;
        step();
        in_valid = 1'b0;
        settle();
        check_eq("l2_valid", l2_valid, 1);
        check_eq("l2_instr", l2_instr, ic);
        check_eq("l2_l1_valid", l1_valid, 0);
        check_eq("l2_l1_instr", l1_instr, 0);
        step();
        wb_pulse(7'd12);

        // lane 2 blocked on busy[5], then released by write-back
        ib = mk(5'd6, 7'd10, 7'd5, 7'd0, 32'h0000_0B0B);
        in_valid = 1'b1; in_instr = ib;
        step();
        in_valid = 1'b0;
        settle();
        check_eq("haz_l2_valid", l2_valid, 0);
        check_eq("haz_l1_valid", l1_valid, 0);
        check_eq("haz_stall0", stall_cnt, 0);
        step();
        settle();
        check_eq("haz_stall1", stall_cnt, 1);
        wb_en = 1'b1; wb_rd = 7'd5;
        settle();
        check_eq("wb_same_cycle_l2", l2_valid, BYP);
        step();
        wb_en = 1'b0;
        settle();
        check_eq("wb_next_cycle_l2", l2_valid, !BYP);
        check_eq("wb_next_cycle_l1", l1_valid, 0);
        step();
        settle();
        s2 = BYP ? 16'd1 : 16'd2;
        check_eq("haz_done_l2", l2_valid, 0);
        check_eq("haz_stall_final", stall_cnt, s2);
        wb_pulse(7'd10);

        // fill to full, reject fifth offer even across a pop, drain in order
        l1_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            cq[i] = mk(5'd1, 7'd0, 7'd0, 7'd0, 32'h1000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = cq[i];
            settle();
            check_eq("fill_in_ready", in_ready, 1);
            step();
        end
        in_instr = cq[4];
        settle();
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_l1_valid", l1_valid, 1);
        step();
        l1_ready = 1'b1;
        settle();
        check_eq("full_pop_in_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            settle();
            check_eq("drain_valid", l1_valid, 1);
            check_eq("drain_instr", l1_instr, cq[i]);
            step();
        end
        settle();
        check_eq("drain_empty", l1_valid, 0);
        check_eq("drain_in_ready", in_ready, 1);
        check_eq("ready_not_stall", stall_cnt, s2);

        // issue rd=9 with write-back to 9 in the same cycle: set wins
        id = mk(5'd2, 7'd9, 7'd0, 7'd0, 32'h0000_0D0D);
        in_valid = 1'b1; in_instr = id;
        step();
        in_valid = 1'b0;
        settle();
        check_eq("prio_l1_valid", l1_valid, 1);
        check_eq("prio_l1_instr", l1_instr, id);
        wb_en = 1'b1; wb_rd = 7'd9;
        step();
        wb_en = 1'b0;
        ie = mk(5'd2, 7'd11, 7'd9, 7'd0, 32'h0000_0E0E);
        in_valid = 1'b1; in_instr = ie;
        step();
        in_valid = 1'b0;
        settle();
        check_eq("prio_busy9_blocks", l1_valid, 0);
        step();
        settle();
        check_eq("prio_stall", stall_cnt, s2 + 16'd1);
        wb_en = 1'b1; wb_rd = 7'd9;
        settle();
        check_eq("prio_wb_same", l1_valid, BYP);
        step();
        wb_en = 1'b0;
        settle();
        check_eq("prio_wb_next", l1_valid, !BYP);
        step();
        settle();
        s4 = s2 + (BYP ? 16'd1 : 16'd2);
        check_eq("prio_drained", l1_valid, 0);
        check_eq("prio_stall_final", stall_cnt, s4);
        wb_pulse(7'd11);

        // asynchronous reset with 3 entries buffered and busy[7] set
        in_valid = 1'b1; in_instr = mk(5'd1, 7'd7, 7'd0, 7'd0, 32'h0000_0707);
        step();
        in_valid = 1'b0;
        step();
        l1_ready = 1'b0;
        in_valid = 1'b1; in_instr = mk(5'd1, 7'd3, 7'd7, 7'd0, 32'h1);
        step();
        in_instr = mk(5'd1, 7'd4, 7'd0, 7'd0, 32'h2);
        step();
        in_instr = mk(5'd1, 7'd6, 7'd0, 7'd0, 32'h3);
        step();
        in_valid = 1'b0;
        settle();
        check_eq("pre_rst_stall", stall_cnt, s4 + 16'd2);
        check_eq("pre_rst_in_ready", in_ready, 1);
        check_eq("pre_rst_l1_valid", l1_valid, 0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready", in_ready, 0);
        check_eq("arst_l1_valid", l1_valid, 0);
        check_eq("arst_l2_valid", l2_valid, 0);
        check_eq("arst_l1_instr", l1_instr, 0);
        check_eq("arst_stall", stall_cnt, 0);
        step();
        rst_n = 1'b1;
        settle();
        check_eq("arst_rel_in_ready", in_ready, 1);
        check_eq("arst_rel_empty", l1_valid, 0);
        l1_ready = 1'b1;
        ih = mk(5'd1, 7'd8, 7'd7, 7'd7, 32'h0000_0808);
        in_valid = 1'b1; in_instr = ih;
        step();
        in_valid = 1'b0;
        settle();
        check_eq("arst_busy_clear", l1_valid, 1);
        check_eq("arst_busy_instr", l1_instr, ih);
        step();
        wb_pulse(7'd8);

        // long forced hazard: counter saturates
        in_valid = 1'b1; in_instr = mk(5'd1, 7'd7, 7'd0, 7'd0, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; in_instr = mk(5'd1, 7'd1, 7'd7, 7'd0, 32'h0);
        step();
        in_valid = 1'b0;
        repeat (100) step();
        settle();
        check_eq("sat_count100", stall_cnt, 16'd100);
        repeat (65435) step();
        settle();
        check_eq("sat_reach", stall_cnt, 16'hFFFF);
        repeat (4465) step();
        settle();
        check_eq("sat_hold", stall_cnt, 16'hFFFF);
        wb_pulse(7'd7);
        step();
        settle();
        check_eq("sat_released", l1_valid, 0);
        check_eq("sat_after", stall_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
